// File: rtl/alu_serial_pkg.sv
// Shared definitions for the digit-serial ALU: op codes, decimal-adjust
// constants and FSM state encoding.
package alu_serial_pkg;

  typedef enum logic [2:0] {
    ALU_SOP_ADD  = 3'd0,
    ALU_SOP_SUB  = 3'd1,
    ALU_SOP_ROL  = 3'd2,
    ALU_SOP_ROR  = 3'd3,
    ALU_SOP_PASS = 3'd4
  } alu_sop_e;

  // Decimal adjust: a digit sum above the limit is corrected by adding 6.
  localparam int ALU_DEC_LIMIT = 9;
  localparam int ALU_DEC_CORR  = 6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_serial_digit.sv
// One-digit combinational slice: add/sub (binary or BCD), rotate step, pass.
module alu_serial_digit
  import alu_serial_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] da,
  input  logic [DIGIT_W-1:0] db,
  input  logic               c,
  input  logic [2:0]         op,
  input  logic               decimal,
  output logic [DIGIT_W-1:0] dr,
  output logic               co
);

  // Decimal arithmetic only has meaning for 4-bit digits.
  localparam bit                 DEC_OK = (DIGIT_W == 4);
  localparam logic [DIGIT_W:0]   LIMIT  = (DIGIT_W+1)'(ALU_DEC_LIMIT);
  localparam logic [DIGIT_W-1:0] NINE   = DIGIT_W'(ALU_DEC_LIMIT);
  localparam logic [DIGIT_W-1:0] CORR   = DIGIT_W'(ALU_DEC_CORR);

  logic               dec;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   s;

  assign dec = decimal & DEC_OK;

  // Digit operation; unknown op codes behave as PASS.
  always_comb begin
    dr    = da;
    co    = c;
    b_eff = db;
    s     = '0;
    case (op)
      ALU_SOP_ADD, ALU_SOP_SUB: begin
        if (op == ALU_SOP_SUB) begin
          // 9's complement in BCD, 1's complement in binary; cin=1 is "no borrow".
          b_eff = dec ? (NINE - db) : ~db;
        end
        s = {1'b0, da} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, c};
        if (dec) begin
          if (s > LIMIT) begin
            dr = s[DIGIT_W-1:0] + CORR;
            co = 1'b1;
          end else begin
            dr = s[DIGIT_W-1:0];
            co = 1'b0;
          end
        end else begin
          dr = s[DIGIT_W-1:0];
          co = s[DIGIT_W];
        end
      end
      ALU_SOP_ROL: begin
        dr = {da[DIGIT_W-2:0], c};
        co = da[DIGIT_W-1];
      end
      ALU_SOP_ROR: begin
        dr = {c, da[DIGIT_W-1:1]};
        co = da[0];
      end
      default: begin
        dr = da;
        co = c;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: processes one DIGIT_W digit per clock through a single
// digit slice, chaining carry through a register, with start/busy/done.
//
//   state  | meaning
//   S_IDLE | waiting for start; result/cout/zero hold last completion
//   S_RUN  | one digit per cycle, cnt counts remaining digits down to 0
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 4,
  localparam int W      = DIGIT_W * DIGITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         decimal,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         zero
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

  alu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    idx;
  logic             carry_q;
  logic [W-1:0]     a_q, b_q;
  logic [2:0]       op_q;
  logic             dec_q;
  logic [W-1:0]     work_q, work_d;
  logic [DIGIT_W-1:0] dr;
  logic             dco;
  logic             last;

  assign busy = (state_q == S_RUN);
  assign last = (cnt_q == '0);

  // ROR walks from the top digit down; everything else walks upward.
  assign idx = (op_q == ALU_SOP_ROR) ? cnt_q : (CNT_LAST - cnt_q);

  alu_serial_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .da      (a_q[idx*DIGIT_W +: DIGIT_W]),
    .db      (b_q[idx*DIGIT_W +: DIGIT_W]),
    .c       (carry_q),
    .op      (op_q),
    .decimal (dec_q),
    .dr      (dr),
    .co      (dco)
  );

  // Working word with the current digit slot replaced.
  always_comb begin
    work_d = work_q;
    work_d[idx*DIGIT_W +: DIGIT_W] = dr;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, digit stepping and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dec_q   <= 1'b0;
      work_q  <= '0;
      result  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start) begin
          a_q     <= a;
          b_q     <= b;
          op_q    <= op;
          dec_q   <= decimal;
          carry_q <= cin;
          cnt_q   <= CNT_LAST;
          work_q  <= '0;
        end
      end else begin
        carry_q <= dco;
        work_q  <= work_d;
        cnt_q   <= cnt_q - 1'b1;
        if (last) begin
          result <= work_d;
          cout   <= dco;
          zero   <= (work_d == '0);
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Directed self-checking bench for alu_serial with DIGITS=4, DIGIT_W=4.
module tb_alu_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        decimal = 1'b0;
  logic        busy, done, cout, zero;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  alu_serial #(.DIGIT_W(4), .DIGITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .decimal (decimal),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, then wait for done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] va,
                        input logic [15:0] vb, input logic c, input logic d,
                        input logic [15:0] er, input logic ec, input logic ez);
    int busy_cnt;
    int cyc;
    bit seen;
    @(negedge clk);
    op = o; a = va; b = vb; cin = c; decimal = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~va; b = ~vb; cin = ~c; decimal = ~d; op = 3'd5;
    busy_cnt = 0;
    seen = 1'b0;
    for (cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done"}, {31'd0, seen}, 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, 32'd4);
    check({tag, "_result"}, {16'd0, result}, {16'd0, er});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    @(negedge clk);
    check({tag, "_done_once"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    int dcnt;

    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_bin",  3'd0, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("add_dec",  3'd0, 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    run_op("sub_dec",  3'd1, 16'h0100, 16'h0001, 1'b1, 1'b1, 16'h0099, 1'b1, 1'b0);
    run_op("sub_bin",  3'd1, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    run_op("add_dec2", 3'd0, 16'h0458, 16'h0277, 1'b1, 1'b1, 16'h0736, 1'b0, 1'b0);
    run_op("rol",      3'd2, 16'h8001, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b0);
    run_op("ror",      3'd3, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h4000, 1'b1, 1'b0);
    run_op("pass6",    3'd6, 16'h1234, 16'hFFFF, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);

    // start pulsed while busy must be ignored.
    @(negedge clk);
    op = 3'd0; a = 16'h0001; b = 16'h0001; cin = 1'b0; decimal = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    op = 3'd4; a = 16'hBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("ign_done", {31'd0, seen}, 32'd1);
    check("ign_result", {16'd0, result}, 32'h0002);
    @(negedge clk);
    check("ign_no_rerun", {31'd0, busy}, 32'd0);

    // start held through the done cycle is accepted back to back.
    @(negedge clk);
    op = 3'd0; a = 16'h0010; b = 16'h0020; cin = 1'b0; decimal = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("b2b_first_done", {31'd0, seen}, 32'd1);
    check("b2b_first_result", {16'd0, result}, 32'h0030);
    op = 3'd4; a = 16'h5A5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    seen = 1'b0;
    for (cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("b2b_second_done", {31'd0, seen}, 32'd1);
    check("b2b_second_result", {16'd0, result}, 32'h5A5A);

    // Reset in the middle of digit 2 discards the operation.
    @(negedge clk);
    op = 3'd0; a = 16'h0FFF; b = 16'h0001; cin = 1'b0; decimal = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", {16'd0, result}, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("post_rst_quiet", dcnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
